mem_ifetch_responder: RTL and testbench

//  Memory-controller side of the instruction-fetch port: answers one fetcher request (en + pc) by

---
 rtl/mem_ifetch_responder_if.sv | 25 ++
 rtl/mem_ifetch_responder.sv | 128 ++++++++++++
 tb/tb_mem_ifetch_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_ifetch_responder_if.sv
// Fetcher request/response and RAM bus signals of the instruction-fetch responder.
// master = fetcher/arbiter/RAM side, slave = responder.
interface mem_ifetch_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  en_signal_from_if;
  logic [ADDR_WIDTH-1:0] pc_from_if;
  logic                  drop_flag_from_if;
  logic [31:0]           inst_to_if;
  logic                  ok_flag_to_if;
  logic                  bus_req;
  logic                  bus_gnt;
  logic [ADDR_WIDTH-1:0] mem_a_out;
  logic [7:0]            mem_din_in;

  modport master (
    output en_signal_from_if, pc_from_if, drop_flag_from_if, bus_gnt, mem_din_in,
    input  inst_to_if, ok_flag_to_if, bus_req, mem_a_out
  );

  modport slave (
    input  en_signal_from_if, pc_from_if, drop_flag_from_if, bus_gnt, mem_din_in,
    output inst_to_if, ok_flag_to_if, bus_req, mem_a_out
  );
endinterface

// File: rtl/mem_ifetch_responder.sv
// Instruction-fetch responder: reads 4 bytes over the shared RAM bus, returns a little-endian word with a 1-cycle ok pulse.
// Latency 7 cycles from en with immediate grant (+1 per grant wait); rdy_in low stalls and restarts the read, drop aborts.
module mem_ifetch_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_BYTES = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  mem_ifetch_responder_if.slave ifp
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, READ} state_t;

  localparam logic [2:0] LAST_CNT = 3'(INST_BYTES);

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [INST_BYTES-2:0][7:0] bytes_q, bytes_d;
  logic                       restart_q, restart_d;
  logic                       ok_q, ok_d;
  logic                       req_q, req_d;
  logic [31:0]                inst_q, inst_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      bytes_q   <= '0;
      restart_q <= 1'b0;
      ok_q      <= 1'b0;
      req_q     <= 1'b0;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      bytes_q   <= bytes_d;
      restart_q <= restart_d;
      ok_q      <= ok_d;
      req_q     <= req_d;
      inst_q    <= inst_d;
    end
  end

  // cnt_q counts READ edges: edge with cnt=c issues address pc+c+1 and captures byte c-1.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    bytes_d   = bytes_q;
    restart_d = restart_q;
    ok_d      = ok_q;
    req_d     = req_q;
    inst_d    = inst_q;

    if (ifp.drop_flag_from_if) begin
      state_d   = IDLE;
      addr_d    = '0;
      cnt_d     = '0;
      bytes_d   = '0;
      restart_d = 1'b0;
      ok_d      = 1'b0;
      req_d     = 1'b0;
    end else if (!rdy_in) begin
      // RAM keeps returning data while stalled, so whatever was collected is stale on resume.
      if (state_q == READ) restart_d = 1'b1;
    end else begin
      ok_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ifp.en_signal_from_if) begin
            pc_d    = ifp.pc_from_if;
            req_d   = 1'b1;
            state_d = WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (ifp.bus_gnt) begin
            state_d = READ;
            addr_d  = pc_q;
            cnt_d   = '0;
          end
        end
        READ: begin
          if (!ifp.bus_gnt) begin
            state_d   = WAIT_GNT;
            addr_d    = '0;
            cnt_d     = '0;
            bytes_d   = '0;
            restart_d = 1'b0;
          end else if (restart_q) begin
            addr_d    = pc_q;
            cnt_d     = '0;
            bytes_d   = '0;
            restart_d = 1'b0;
          end else if (cnt_q == LAST_CNT) begin
            inst_d  = {ifp.mem_din_in, bytes_q};
            ok_d    = 1'b1;
            req_d   = 1'b0;
            addr_d  = '0;
            cnt_d   = '0;
            bytes_d = '0;
            state_d = IDLE;
          end else begin
            if (cnt_q < LAST_CNT - 3'd1) addr_d = pc_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
            else                         addr_d = '0;
            for (int i = 0; i < INST_BYTES - 1; i++) begin
              if (cnt_q == 3'(i + 1)) bytes_d[i] = ifp.mem_din_in;
            end
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ifp.inst_to_if    = inst_q;
  assign ifp.ok_flag_to_if = ok_q;
  assign ifp.bus_req       = req_q;
  assign ifp.mem_a_out     = addr_q;
endmodule

// File: tb/tb_mem_ifetch_responder.sv
// Directed bench for mem_ifetch_responder with a one-cycle-latency byte RAM model.
module tb_mem_ifetch_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_ifetch_responder_if #(.ADDR_WIDTH(32)) ifc ();

  mem_ifetch_responder #(.ADDR_WIDTH(32), .INST_BYTES(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .ifp    (ifc.slave)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0102: return 8'h00;
      32'h0000_0103: return 8'h00;
      32'h0000_0200: return 8'h93;
      32'h0000_0201: return 8'h00;
      32'h0000_0202: return 8'h10;
      32'h0000_0203: return 8'h00;
      32'h0000_0300: return 8'h78;
      32'h0000_0301: return 8'h56;
      32'h0000_0302: return 8'h34;
      32'h0000_0303: return 8'h12;
      32'hFFFF_FFFE: return 8'hEF;
      32'hFFFF_FFFF: return 8'hBE;
      32'h0000_0000: return 8'hAD;
      32'h0000_0001: return 8'hDE;
      default:       return 8'hA5;
    endcase
  endfunction

  always @(posedge clk_in) ifc.mem_din_in <= ram_byte(ifc.mem_a_out);

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc);
    ifc.en_signal_from_if = 1'b1;
    ifc.pc_from_if        = pc;
    tick();
    ifc.en_signal_from_if = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (ifc.bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got=%b exp=0", ifc.bus_req); end
    checks++; if (ifc.mem_a_out !== 32'h0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", ifc.mem_a_out); end
    checks++; if (ifc.ok_flag_to_if !== 1'b0) begin failures++; $display("FAIL reset_ok got=%b exp=0", ifc.ok_flag_to_if); end
    checks++; if (ifc.inst_to_if !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", ifc.inst_to_if); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] exp_a [5];
    exp_a = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h0};
    ifc.bus_gnt = 1'b1;
    issue(32'h100);
    checks++; if (ifc.bus_req !== 1'b1) begin failures++; $display("FAIL basic_req got=%b exp=1", ifc.bus_req); end
    checks++; if (ifc.mem_a_out !== 32'h0) begin failures++; $display("FAIL basic_a_wait got=%h exp=0", ifc.mem_a_out); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (ifc.mem_a_out !== exp_a[k]) begin failures++; $display("FAIL basic_addr%0d got=%h exp=%h", k, ifc.mem_a_out, exp_a[k]); end
      checks++; if (ifc.ok_flag_to_if !== 1'b0) begin failures++; $display("FAIL basic_early_ok%0d got=%b exp=0", k, ifc.ok_flag_to_if); end
    end
    tick();
    checks++; if (ifc.ok_flag_to_if !== 1'b1) begin failures++; $display("FAIL basic_ok got=%b exp=1", ifc.ok_flag_to_if); end
    checks++; if (ifc.inst_to_if !== 32'h0000_0513) begin failures++; $display("FAIL basic_inst got=%h exp=00000513", ifc.inst_to_if); end
    checks++; if (ifc.bus_req !== 1'b0) begin failures++; $display("FAIL basic_req_done got=%b exp=0", ifc.bus_req); end
    tick();
    checks++; if (ifc.ok_flag_to_if !== 1'b0) begin failures++; $display("FAIL basic_ok_pulse got=%b exp=0", ifc.ok_flag_to_if); end
    checks++; if (ifc.inst_to_if !== 32'h0000_0513) begin failures++; $display("FAIL basic_inst_hold got=%h exp=00000513", ifc.inst_to_if); end
  endtask

  task automatic test_gnt_delay();
    int n;
    ifc.bus_gnt = 1'b0;
    issue(32'h100);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ifc.mem_a_out !== 32'h0 || ifc.bus_req !== 1'b1) begin
        failures++; $display("FAIL gnt_wait%0d got a=%h req=%b exp a=0 req=1", k, ifc.mem_a_out, ifc.bus_req);
      end
    end
    ifc.bus_gnt = 1'b1;
    n = 0;
    while (ifc.ok_flag_to_if !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (n !== 6) begin failures++; $display("FAIL gnt_latency got=%0d exp=6", n); end
    checks++; if (ifc.inst_to_if !== 32'h0000_0513) begin failures++; $display("FAIL gnt_inst got=%h exp=00000513", ifc.inst_to_if); end
    tick();
  endtask

  task automatic test_drop();
    int n;
    logic saw_ok;
    ifc.bus_gnt = 1'b1;
    issue(32'h100);
    tick(); tick(); tick();
    ifc.drop_flag_from_if = 1'b1;
    tick();
    ifc.drop_flag_from_if = 1'b0;
    checks++; if (ifc.bus_req !== 1'b0) begin failures++; $display("FAIL drop_req got=%b exp=0", ifc.bus_req); end
    checks++; if (ifc.mem_a_out !== 32'h0) begin failures++; $display("FAIL drop_a got=%h exp=0", ifc.mem_a_out); end
    saw_ok = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(); if (ifc.ok_flag_to_if === 1'b1) saw_ok = 1'b1; end
    checks++; if (saw_ok !== 1'b0) begin failures++; $display("FAIL drop_no_ok got=%b exp=0", saw_ok); end
    // drop and en together: en must be ignored
    ifc.en_signal_from_if = 1'b1; ifc.pc_from_if = 32'h200; ifc.drop_flag_from_if = 1'b1;
    tick();
    ifc.en_signal_from_if = 1'b0; ifc.drop_flag_from_if = 1'b0;
    checks++; if (ifc.bus_req !== 1'b0) begin failures++; $display("FAIL drop_en_req got=%b exp=0", ifc.bus_req); end
    tick();
    issue(32'h200);
    n = 0;
    while (ifc.ok_flag_to_if !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (n !== 6) begin failures++; $display("FAIL drop_next_latency got=%0d exp=6", n); end
    checks++; if (ifc.inst_to_if !== 32'h0010_0093) begin failures++; $display("FAIL drop_next_inst got=%h exp=00100093", ifc.inst_to_if); end
    tick();
  endtask

  task automatic test_stall();
    int n;
    issue(32'h300);
    tick(); tick(); tick();
    rdy_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (ifc.mem_a_out !== 32'h302 || ifc.bus_req !== 1'b1 || ifc.ok_flag_to_if !== 1'b0) begin
        failures++; $display("FAIL stall_freeze%0d got a=%h req=%b ok=%b exp a=302 req=1 ok=0", k, ifc.mem_a_out, ifc.bus_req, ifc.ok_flag_to_if);
      end
    end
    rdy_in = 1'b1;
    tick();
    checks++; if (ifc.mem_a_out !== 32'h300) begin failures++; $display("FAIL stall_restart_a got=%h exp=300", ifc.mem_a_out); end
    n = 0;
    while (ifc.ok_flag_to_if !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (n !== 5) begin failures++; $display("FAIL stall_latency got=%0d exp=5", n); end
    checks++; if (ifc.inst_to_if !== 32'h1234_5678) begin failures++; $display("FAIL stall_inst got=%h exp=12345678", ifc.inst_to_if); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    int n;
    issue(32'h300);
    tick(); tick();
    #2 rst_in = 1'b1;
    #1;
    checks++; if (ifc.bus_req !== 1'b0 || ifc.mem_a_out !== 32'h0 || ifc.ok_flag_to_if !== 1'b0 || ifc.inst_to_if !== 32'h0) begin
      failures++; $display("FAIL midreset got req=%b a=%h ok=%b inst=%h exp all 0", ifc.bus_req, ifc.mem_a_out, ifc.ok_flag_to_if, ifc.inst_to_if);
    end
    tick();
    rst_in = 1'b0;
    tick();
    issue(32'h100);
    n = 0;
    while (ifc.ok_flag_to_if !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (n !== 6) begin failures++; $display("FAIL midreset_latency got=%0d exp=6", n); end
    checks++; if (ifc.inst_to_if !== 32'h0000_0513) begin failures++; $display("FAIL midreset_inst got=%h exp=00000513", ifc.inst_to_if); end
    tick();
  endtask

  task automatic test_wrap_back_to_back();
    int n;
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    issue(32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ifc.mem_a_out !== exp_a[k]) begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, ifc.mem_a_out, exp_a[k]); end
    end
    tick(); tick();
    checks++; if (ifc.ok_flag_to_if !== 1'b1) begin failures++; $display("FAIL wrap_ok got=%b exp=1", ifc.ok_flag_to_if); end
    checks++; if (ifc.inst_to_if !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wrap_inst got=%h exp=deadbeef", ifc.inst_to_if); end
    issue(32'h200);
    checks++; if (ifc.bus_req !== 1'b1) begin failures++; $display("FAIL b2b_req got=%b exp=1", ifc.bus_req); end
    n = 0;
    while (ifc.ok_flag_to_if !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (n !== 6) begin failures++; $display("FAIL b2b_latency got=%0d exp=6", n); end
    checks++; if (ifc.inst_to_if !== 32'h0010_0093) begin failures++; $display("FAIL b2b_inst got=%h exp=00100093", ifc.inst_to_if); end
    tick();
  endtask

  initial begin
    ifc.en_signal_from_if = 1'b0;
    ifc.pc_from_if        = 32'h0;
    ifc.drop_flag_from_if = 1'b0;
    ifc.bus_gnt           = 1'b1;
    test_reset();
    test_basic();
    test_gnt_delay();
    test_drop();
    test_stall();
    test_reset_mid_read();
    test_wrap_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
